// File: rtl/rob_commit_if.sv
// Bundle of dispatch, write-back, operand-read, flush and retire signals for rob_commit.
// The master side drives dispatch/write-back/lookups; the slave side is the reorder buffer.
interface rob_commit_if #(
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32
);
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_reg;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;

    logic              wb0_valid;
    logic [TAG_W-1:0]  wb0_tag;
    logic [DATA_W-1:0] wb0_value;
    logic              wb1_valid;
    logic [TAG_W-1:0]  wb1_tag;
    logic [DATA_W-1:0] wb1_value;

    logic [TAG_W-1:0]  rd_tag;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_value;

    logic              flush;

    logic              commit_valid;
    logic [TAG_W-1:0]  commit_tag;
    logic [REG_W-1:0]  commit_reg;
    logic [DATA_W-1:0] commit_value;

    logic [TAG_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output alloc_valid, alloc_reg,
        input  alloc_ready, alloc_tag,
        output wb0_valid, wb0_tag, wb0_value,
        output wb1_valid, wb1_tag, wb1_value,
        output rd_tag,
        input  rd_ready, rd_value,
        output flush,
        input  commit_valid, commit_tag, commit_reg, commit_value,
        input  count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_reg,
        output alloc_ready, alloc_tag,
        input  wb0_valid, wb0_tag, wb0_value,
        input  wb1_valid, wb1_tag, wb1_value,
        input  rd_tag,
        output rd_ready, rd_value,
        input  flush,
        output commit_valid, commit_tag, commit_reg, commit_value,
        output count, empty, full
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates in dispatch order, absorbs two write-back ports by tag,
// and retires completed entries strictly in order, one per cycle.
module rob_commit #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    rob_commit_if.slave bus
);
    logic              r_valid [DEPTH];
    logic              r_done  [DEPTH];
    logic [REG_W-1:0]  r_reg   [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              r_commit_valid;
    logic [TAG_W-1:0]  r_commit_tag;
    logic [REG_W-1:0]  r_commit_reg;
    logic [DATA_W-1:0] r_commit_value;

    logic w_full;
    logic w_empty;
    logic w_alloc_fire;
    logic w_commit_fire;
    logic w_wb0_hit;
    logic w_wb1_hit;

    always_comb begin
        w_full        = (r_count == (TAG_W+1)'(DEPTH));
        w_empty       = (r_count == '0);
        w_alloc_fire  = bus.alloc_valid && !w_full;
        w_commit_fire = r_valid[r_head] && r_done[r_head];
        w_wb0_hit     = bus.wb0_valid && r_valid[bus.wb0_tag] && !r_done[bus.wb0_tag];
        // On a same-tag collision port 0 owns the entry.
        w_wb1_hit     = bus.wb1_valid && r_valid[bus.wb1_tag] && !r_done[bus.wb1_tag] &&
                        !(bus.wb0_valid && (bus.wb0_tag == bus.wb1_tag));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_tag   <= '0;
            r_commit_reg   <= '0;
            r_commit_value <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
                r_reg[i]   <= '0;
                r_value[i] <= '0;
            end
        end else if (bus.flush) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
            end
        end else begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_commit_fire) begin
                r_head         <= r_head + 1'b1;
                r_commit_tag   <= r_head;
                r_commit_reg   <= r_reg[r_head];
                r_commit_value <= r_value[r_head];
            end
            r_commit_valid <= w_commit_fire;
            r_count        <= r_count + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_commit_fire);

            // Tail is never valid when alloc fires and head is already done when it
            // commits, so alloc, write-back and retire never collide on one entry.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (r_tail == TAG_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_done[i]  <= 1'b0;
                    r_reg[i]   <= bus.alloc_reg;
                end else if (w_commit_fire && (r_head == TAG_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_wb0_hit && (bus.wb0_tag == TAG_W'(i))) begin
                    r_done[i]  <= 1'b1;
                    r_value[i] <= bus.wb0_value;
                end else if (w_wb1_hit && (bus.wb1_tag == TAG_W'(i))) begin
                    r_done[i]  <= 1'b1;
                    r_value[i] <= bus.wb1_value;
                end
            end
        end
    end

    assign bus.alloc_ready  = !w_full;
    assign bus.alloc_tag    = r_tail;
    assign bus.rd_ready     = r_valid[bus.rd_tag] && r_done[bus.rd_tag];
    assign bus.rd_value     = r_value[bus.rd_tag];
    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_tag   = r_commit_tag;
    assign bus.commit_reg   = r_commit_reg;
    assign bus.commit_value = r_commit_value;
    assign bus.count        = r_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit: ordering, full/wrap, dual write-back,
// flush and asynchronous reset behaviour against hand-computed expectations.
module tb_rob_commit;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    rob_commit_if #(.TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W)) bus ();

    rob_commit #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .REG_W (REG_W),
        .DATA_W(DATA_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_reg   = '0;
        bus.wb0_valid   = 1'b0;
        bus.wb0_tag     = '0;
        bus.wb0_value   = '0;
        bus.wb1_valid   = 1'b0;
        bus.wb1_tag     = '0;
        bus.wb1_value   = '0;
        bus.rd_tag      = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic do_alloc(input logic [REG_W-1:0] r);
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = r;
        step();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic do_wb0(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        bus.wb0_valid = 1'b1;
        bus.wb0_tag   = t;
        bus.wb0_value = v;
        step();
        bus.wb0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic check_commit(input string tag, input logic [TAG_W-1:0] t,
                                input logic [REG_W-1:0] r, input logic [DATA_W-1:0] v);
        check_eq({tag, "_valid"}, bus.commit_valid, 1);
        check_eq({tag, "_tag"},   bus.commit_tag, t);
        check_eq({tag, "_reg"},   bus.commit_reg, r);
        check_eq({tag, "_value"}, bus.commit_value, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAG_W-1:0] t;
        drive_idle();
        step();
        step();
        rst = 1'b0;

        // Reset values
        check_eq("rst_count",   bus.count, 0);
        check_eq("rst_empty",   bus.empty, 1);
        check_eq("rst_full",    bus.full, 0);
        check_eq("rst_ready",   bus.alloc_ready, 1);
        check_eq("rst_tag",     bus.alloc_tag, 0);
        check_eq("rst_cvalid",  bus.commit_valid, 0);

        // Out-of-order completion, in-order retire
        do_alloc(5'd1);
        do_alloc(5'd2);
        do_alloc(5'd3);
        check_eq("ooo_count", bus.count, 3);
        check_eq("ooo_atag",  bus.alloc_tag, 3);
        do_wb0(3'd2, 32'h30);
        bus.rd_tag = 3'd2;
        #1;
        check_eq("ooo_rd_ready", bus.rd_ready, 1);
        check_eq("ooo_rd_value", bus.rd_value, 32'h30);
        check_eq("ooo_no_commit0", bus.commit_valid, 0);
        step();
        check_eq("ooo_no_commit1", bus.commit_valid, 0);
        do_wb0(3'd0, 32'h10);
        check_eq("ooo_no_bypass", bus.commit_valid, 0);
        do_wb0(3'd1, 32'h20);
        check_commit("ooo_c0", 3'd0, 5'd1, 32'h10);
        step();
        check_commit("ooo_c1", 3'd1, 5'd2, 32'h20);
        step();
        check_commit("ooo_c2", 3'd2, 5'd3, 32'h30);
        check_eq("ooo_count_end", bus.count, 0);
        step();
        check_eq("ooo_idle", bus.commit_valid, 0);
        check_eq("ooo_empty", bus.empty, 1);

        // Asynchronous reset with three live entries
        do_alloc(5'd4);
        do_alloc(5'd5);
        do_alloc(5'd6);
        do_wb0(3'd3, 32'h40);
        bus.rd_tag = 3'd3;
        #1;
        check_eq("mid_rd_pre", bus.rd_ready, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_count",  bus.count, 0);
        check_eq("mid_empty",  bus.empty, 1);
        check_eq("mid_atag",   bus.alloc_tag, 0);
        check_eq("mid_ready",  bus.alloc_ready, 1);
        check_eq("mid_cvalid", bus.commit_valid, 0);
        check_eq("mid_ctag",   bus.commit_tag, 0);
        check_eq("mid_creg",   bus.commit_reg, 0);
        check_eq("mid_cvalue", bus.commit_value, 0);
        check_eq("mid_rd",     bus.rd_ready, 0);
        step();
        rst = 1'b0;

        // Fill to capacity, refuse extra alloc, then retire one
        for (int i = 0; i < 8; i++) begin
            do_alloc(REG_W'(8 + i));
        end
        check_eq("full_count", bus.count, 8);
        check_eq("full_full",  bus.full, 1);
        check_eq("full_ready", bus.alloc_ready, 0);
        check_eq("full_atag",  bus.alloc_tag, 0);
        do_alloc(5'd31);
        check_eq("full_ninth_count", bus.count, 8);
        check_eq("full_ninth_atag",  bus.alloc_tag, 0);
        do_wb0(3'd0, 32'h55);
        check_eq("full_wb_count", bus.count, 8);
        // Alloc offered on the commit edge must still be refused
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 5'd20;
        step();
        check_commit("full_c0", 3'd0, 5'd8, 32'h55);
        check_eq("full_post_count", bus.count, 7);
        check_eq("full_post_ready", bus.alloc_ready, 1);
        check_eq("full_post_atag",  bus.alloc_tag, 0);
        step();
        bus.alloc_valid = 1'b0;
        check_eq("full_refill_count", bus.count, 8);
        check_eq("full_refill_atag",  bus.alloc_tag, 1);
        pulse_reset();

        // Wrap: twelve alloc/wb/commit sequences
        for (int i = 0; i < 12; i++) begin
            t = TAG_W'(i % 8);
            check_eq("wrap_atag", bus.alloc_tag, t);
            do_alloc(REG_W'(i));
            check_eq("wrap_count", bus.count, 1);
            do_wb0(t, 32'h100 + i);
            check_eq("wrap_no_commit", bus.commit_valid, 0);
            step();
            check_commit("wrap_c", t, REG_W'(i), 32'h100 + i);
            check_eq("wrap_count_end", bus.count, 0);
        end
        pulse_reset();

        // Dual write-back and same-tag collision
        do_alloc(5'd1);
        do_alloc(5'd2);
        bus.wb0_valid = 1'b1; bus.wb0_tag = 3'd1; bus.wb0_value = 32'hA;
        bus.wb1_valid = 1'b1; bus.wb1_tag = 3'd0; bus.wb1_value = 32'hB;
        step();
        bus.wb0_valid = 1'b0;
        bus.wb1_valid = 1'b0;
        step();
        check_commit("dual_c0", 3'd0, 5'd1, 32'hB);
        step();
        check_commit("dual_c1", 3'd1, 5'd2, 32'hA);
        do_alloc(5'd3);
        bus.wb0_valid = 1'b1; bus.wb0_tag = 3'd2; bus.wb0_value = 32'hC1;
        bus.wb1_valid = 1'b1; bus.wb1_tag = 3'd2; bus.wb1_value = 32'hC2;
        step();
        bus.wb0_valid = 1'b0;
        bus.wb1_valid = 1'b0;
        bus.rd_tag = 3'd2;
        #1;
        check_eq("coll_rd_ready", bus.rd_ready, 1);
        check_eq("coll_rd_value", bus.rd_value, 32'hC1);
        step();
        check_commit("coll_c2", 3'd2, 5'd3, 32'hC1);
        pulse_reset();

        // Flush with five live entries, two done
        for (int i = 0; i < 5; i++) begin
            do_alloc(REG_W'(1 + i));
        end
        bus.wb0_valid = 1'b1; bus.wb0_tag = 3'd1; bus.wb0_value = 32'h44;
        bus.wb1_valid = 1'b1; bus.wb1_tag = 3'd2; bus.wb1_value = 32'h55;
        step();
        bus.wb1_valid = 1'b0;
        bus.rd_tag = 3'd1;
        #1;
        check_eq("fl_pre_count", bus.count, 5);
        check_eq("fl_pre_rd",    bus.rd_ready, 1);
        check_eq("fl_pre_atag",  bus.alloc_tag, 5);
        bus.flush       = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_reg   = 5'd9;
        bus.wb0_valid   = 1'b1; bus.wb0_tag = 3'd0; bus.wb0_value = 32'h66;
        step();
        drive_idle();
        bus.rd_tag = 3'd1;
        #1;
        check_eq("fl_count",  bus.count, 0);
        check_eq("fl_empty",  bus.empty, 1);
        check_eq("fl_atag",   bus.alloc_tag, 0);
        check_eq("fl_cvalid", bus.commit_valid, 0);
        check_eq("fl_rd",     bus.rd_ready, 0);
        do_wb0(3'd0, 32'h77);
        step();
        check_eq("fl_stale_cvalid", bus.commit_valid, 0);
        check_eq("fl_stale_count",  bus.count, 0);
        bus.rd_tag = 3'd0;
        #1;
        check_eq("fl_stale_rd", bus.rd_ready, 0);
        check_eq("fl_next_atag", bus.alloc_tag, 0);
        do_alloc(5'd7);
        check_eq("fl_next_count", bus.count, 1);
        do_wb0(3'd0, 32'h99);
        step();
        check_commit("fl_c0", 3'd0, 5'd7, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
